// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default timing and width helpers for the rPLL lock sequencer.
package pll_seq_pkg;
    typedef enum logic [4:0] {
        PLL_RST   = 5'b00001,
        WAIT_LOCK = 5'b00010,
        STABLE    = 5'b00100,
        RUN       = 5'b01000,
        FAULT     = 5'b10000
    } state_e;
    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES    = 3;
    function automatic int bits_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
    localparam int DEF_CNT_W   = bits_for(max3(DEF_RST_CYCLES, DEF_STABLE_CYCLES, DEF_TIMEOUT_CYCLES));
    localparam int DEF_RETRY_W = bits_for(DEF_MAX_RETRIES + 1);
endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: resets the rPLL, qualifies LOCK and gates the core reset request, with bounded retries.
module pll_lock_sequencer import pll_seq_pkg::*; #(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    localparam int CNT_W   = bits_for(max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)),
    localparam int RETRY_W = bits_for(MAX_RETRIES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic               sys_rst_req_n,
    output logic               locked_ok,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);
    if (RST_CYCLES < 1 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pll_lock_sequencer: RST/STABLE/TIMEOUT_CYCLES must all be >= 1");
    end
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    state_e           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             lock_s, cnt_clr, retry_inc;
    sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            retry_cnt <= (state_n == RUN) ? '0 : retry_cnt + RETRY_W'(retry_inc);
        end
    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        case (state)
            PLL_RST:   state_n = (cnt == RST_LAST) ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: begin
                if (lock_s) state_n = STABLE;
                else if (cnt == TIMEOUT_LAST) begin
                    state_n   = (retry_cnt == RETRY_MAX) ? FAULT : PLL_RST;
                    retry_inc = (retry_cnt != RETRY_MAX);
                end
            end
            STABLE:    state_n = !lock_s ? WAIT_LOCK : (cnt == STABLE_LAST) ? RUN : STABLE;
            RUN:       state_n = lock_s ? RUN : PLL_RST;
            FAULT:     state_n = FAULT;
            default:   state_n = PLL_RST;
        endcase
        // A forced relock beats every other exit, but FAULT only leaves on rst_n.
        if (relock_req && state != FAULT) begin
            state_n   = PLL_RST;
            retry_inc = 1'b0;
        end
        cnt_clr = (state_n != state) || relock_req || state == RUN || state == FAULT;
    end
    assign pll_reset     = (state == PLL_RST);
    assign sys_rst_req_n = (state == RUN);
    assign locked_ok     = (state == RUN);
    assign fault         = (state == FAULT);
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios with a cycle-stamped expectation queue checked by a monitor.
module tb_pll_lock_sequencer;
    typedef struct {
        int         c;
        string      tag;
        logic [5:0] v;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n, pll_lock, relock_req;
    logic       pll_reset, sys_rst_req_n, locked_ok, fault;
    logic [1:0] retry_cnt;
    logic [5:0] obs;
    int         cyc, checks, failures;
    exp_t       sb[$];
    exp_t       e;
    pll_lock_sequencer #(
        .RST_CYCLES(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .relock_req(relock_req),
        .pll_reset(pll_reset), .sys_rst_req_n(sys_rst_req_n), .locked_ok(locked_ok),
        .fault(fault), .retry_cnt(retry_cnt)
    );
    always #5 clk = ~clk;
    assign obs = {pll_reset, sys_rst_req_n, locked_ok, fault, retry_cnt};
    // cyc = posedges since rst_n was last released
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    function automatic logic [5:0] v(input logic pr, input logic sr, input logic lk,
                                     input logic ft, input logic [1:0] rc);
        return {pr, sr, lk, ft, rc};
    endfunction
    task automatic cmp(input string tag, input logic [5:0] o, input logic [5:0] x);
        checks++;
        assert (o === x) else begin
            failures++;
            $error("FAIL %s observed={rst,sysn,ok,flt,retry}=%b expected=%b", tag, o, x);
        end
    endtask
    task automatic push(input int c, input string tag, input logic [5:0] x);
        sb.push_back('{c, tag, x});
    endtask
    task automatic at(input int n);
        int g = 0;
        while (cyc != n && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        checks++;
        assert (cyc == n) else begin
            failures++;
            $error("FAIL wait_cycle observed=%0d expected=%0d", cyc, n);
        end
    endtask
    task automatic drain(input string tag);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain observed=%0d pending expected=0 (next stamp %0d)", tag, sb.size(), sb[0].c);
        end
        sb.delete();
    endtask
    task automatic do_reset(input logic lk);
        rst_n      = 1'b0;
        pll_lock   = lk;
        relock_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    always begin
        @(posedge clk);
        #1;
        if (rst_n)
            while (sb.size() > 0 && sb[0].c == cyc) begin
                e = sb.pop_front();
                cmp(e.tag, obs, e.v);
            end
    end
    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        pll_lock = 1'b0;
        relock_req = 1'b0;
        #12;
        cmp("reset_state", obs, v(1, 0, 0, 0, 0));
        // bring-up, lock loss in RUN, relock in RUN
        do_reset(1'b0);
        cmp("release_c0", obs, v(1, 0, 0, 0, 0));
        push(3,  "pllrst_c3",    v(1, 0, 0, 0, 0));
        push(4,  "waitlock_c4",  v(0, 0, 0, 0, 0));
        push(19, "stable_c19",   v(0, 0, 0, 0, 0));
        push(20, "run_c20",      v(0, 1, 1, 0, 0));
        push(27, "run_c27",      v(0, 1, 1, 0, 0));
        push(28, "lockloss_c28", v(1, 0, 0, 0, 0));
        push(31, "pllrst_c31",   v(1, 0, 0, 0, 0));
        push(32, "waitlock_c32", v(0, 0, 0, 0, 0));
        push(43, "stable_c43",   v(0, 0, 0, 0, 0));
        push(44, "rerun_c44",    v(0, 1, 1, 0, 0));
        push(47, "run_c47",      v(0, 1, 1, 0, 0));
        push(48, "relock_c48",   v(1, 0, 0, 0, 0));
        push(51, "pllrst_c51",   v(1, 0, 0, 0, 0));
        push(52, "waitlock_c52", v(0, 0, 0, 0, 0));
        at(9);  pll_lock = 1'b1;
        at(25); pll_lock = 1'b0;
        at(33); pll_lock = 1'b1;
        at(47); relock_req = 1'b1;
        at(48); relock_req = 1'b0;
        at(54); drain("bringup");
        // one-cycle lock glitch during STABLE
        do_reset(1'b0);
        push(12, "glitch_c12", v(0, 0, 0, 0, 0));
        push(16, "glitch_c16", v(0, 0, 0, 0, 0));
        push(25, "glitch_c25", v(0, 0, 0, 0, 0));
        push(26, "glitch_c26", v(0, 1, 1, 0, 0));
        at(9);  pll_lock = 1'b1;
        at(14); pll_lock = 1'b0;
        at(15); pll_lock = 1'b1;
        at(28); drain("glitch");
        // lock never arrives: retries then FAULT, relock ignored
        do_reset(1'b0);
        push(35,  "to_c35",    v(0, 0, 0, 0, 0));
        push(36,  "to_c36",    v(1, 0, 0, 0, 1));
        push(39,  "to_c39",    v(1, 0, 0, 0, 1));
        push(40,  "to_c40",    v(0, 0, 0, 0, 1));
        push(71,  "to_c71",    v(0, 0, 0, 0, 1));
        push(72,  "to_c72",    v(1, 0, 0, 0, 2));
        push(107, "to_c107",   v(0, 0, 0, 0, 2));
        push(108, "fault_c108", v(0, 0, 0, 1, 2));
        push(112, "fault_c112", v(0, 0, 0, 1, 2));
        at(110); relock_req = 1'b1;
        at(111); relock_req = 1'b0;
        at(114); drain("timeout");
        // relock in WAIT_LOCK restarts the counter and keeps retry_cnt
        do_reset(1'b0);
        push(9,  "wl_c9",    v(0, 0, 0, 0, 0));
        push(10, "wl_c10",   v(1, 0, 0, 0, 0));
        push(13, "wl_c13",   v(1, 0, 0, 0, 0));
        push(14, "wl_c14",   v(0, 0, 0, 0, 0));
        push(45, "wl_c45",   v(0, 0, 0, 0, 0));
        push(46, "wl_c46",   v(1, 0, 0, 0, 1));
        at(9);  relock_req = 1'b1;
        at(10); relock_req = 1'b0;
        at(48); drain("relock_wait");
        // asynchronous reset mid-STABLE, then clean restart with lock held
        do_reset(1'b0);
        at(9);  pll_lock = 1'b1;
        at(14);
        cmp("stable_c14", obs, v(0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst", obs, v(1, 0, 0, 0, 0));
        do_reset(1'b1);
        push(3,  "restart_c3",  v(1, 0, 0, 0, 0));
        push(12, "restart_c12", v(0, 0, 0, 0, 0));
        push(13, "restart_c13", v(0, 1, 1, 0, 0));
        at(15); drain("restart");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
